// File: rtl/rtable_pkg.sv
// rtable_pkg: shared direction/mode types and the dimension-order route function.
package rtable_pkg;
  typedef enum logic [2:0] {
    DIR_LOCAL   = 3'b000,
    DIR_NORTH   = 3'b001,
    DIR_EAST    = 3'b010,
    DIR_SOUTH   = 3'b011,
    DIR_WEST    = 3'b100,
    DIR_INVALID = 3'b111
  } dir_t;
  typedef enum logic {MODE_XY = 1'b0, MODE_YX = 1'b1} route_mode_t;
  typedef logic [7:0] coord_t;
  function automatic dir_t route_calc(input coord_t dx, input coord_t dy, input coord_t my_x,
                                      input coord_t my_y, input route_mode_t mode);
    dir_t xd, yd;
    logic xe, ye;
    xd = dx < my_x ? DIR_WEST : DIR_EAST;
    yd = dy < my_y ? DIR_SOUTH : DIR_NORTH;
    xe = dx == my_x;
    ye = dy == my_y;
    return mode == MODE_XY ? (!xe ? xd : (!ye ? yd : DIR_LOCAL))
                           : (!ye ? yd : (!xe ? xd : DIR_LOCAL));
  endfunction
endpackage

// File: rtl/rtable_fifo.sv
// rtable_fifo: DEPTH-entry synchronous FIFO with occupancy count, full and empty flags.
module rtable_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + PW'(1);
  endfunction
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? nxt(wr_q) : wr_q;
      rd_q  <= do_pop ? nxt(rd_q) : rd_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/rtable_router_stage.sv
// rtable_router_stage: registered mesh route lookup with programmable node/order and output FIFO.
module rtable_router_stage
  import rtable_pkg::*;
#(
  parameter int MESH_X  = 16,
  parameter int MESH_Y  = 16,
  parameter int ID_W    = 8,
  parameter int RESET_X = 7,
  parameter int RESET_Y = 8,
  parameter int DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [7:0]      cfg_x,
  input  logic [7:0]      cfg_y,
  input  logic            cfg_mode,
  output logic            cfg_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_dest,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_port,
  output logic [ID_W-1:0] out_dest,
  output logic            out_err,
  output logic [15:0]     route_cnt,
  output logic [15:0]     err_cnt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 3 + ID_W + 1;
  coord_t my_x_q, my_y_q, dx, dy;
  route_mode_t mode_q;
  logic cfg_err_q;
  logic [15:0] route_cnt_q, err_cnt_q;
  logic [31:0] dest_w;
  logic dest_bad, cfg_bad, push, pop;
  dir_t port_w;
  logic [EW-1:0] head;
  logic [2:0] head_port;
  logic [ID_W-1:0] head_dest;
  logic head_err;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  assign dest_w   = 32'(in_dest);
  assign dx       = coord_t'(dest_w % 32'(MESH_X));
  assign dy       = coord_t'(dest_w / 32'(MESH_X));
  assign dest_bad = dest_w >= 32'(MESH_X * MESH_Y);
  assign cfg_bad  = 32'(cfg_x) >= 32'(MESH_X) || 32'(cfg_y) >= 32'(MESH_Y);
  assign port_w   = dest_bad ? DIR_INVALID : route_calc(dx, dy, my_x_q, my_y_q, mode_q);
  // Occupancy alone gates acceptance, so a pop never frees a slot for the same edge.
  assign in_ready = fifo_count < CW'(DEPTH);
  assign push     = in_valid & in_ready & ~fifo_full;
  assign pop      = out_valid & out_ready;
  rtable_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({port_w, in_dest, dest_bad}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign {head_port, head_dest, head_err} = head;
  assign out_valid = ~fifo_empty;
  assign out_port  = fifo_empty ? 3'b000 : head_port;
  assign out_dest  = fifo_empty ? '0 : head_dest;
  assign out_err   = fifo_empty ? 1'b0 : head_err;
  assign cfg_err   = cfg_err_q;
  assign route_cnt = route_cnt_q;
  assign err_cnt   = err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      my_x_q      <= coord_t'(RESET_X);
      my_y_q      <= coord_t'(RESET_Y);
      mode_q      <= MODE_XY;
      cfg_err_q   <= 1'b0;
      route_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      cfg_err_q   <= cfg_we & cfg_bad;
      my_x_q      <= cfg_we && !cfg_bad ? cfg_x : my_x_q;
      my_y_q      <= cfg_we && !cfg_bad ? cfg_y : my_y_q;
      mode_q      <= cfg_we && !cfg_bad ? route_mode_t'(cfg_mode) : mode_q;
      route_cnt_q <= push && route_cnt_q != 16'hFFFF ? route_cnt_q + 16'd1 : route_cnt_q;
      err_cnt_q   <= push && dest_bad && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;
    end
  end
endmodule

// File: tb/tb_rtable_router_stage.sv
// tb_rtable_router_stage: 16x16 and 10x10 instances checked against a coordinate-level model.
module tb_rtable_router_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we [2], cfg_mode [2], in_valid [2], out_ready [2];
  logic [7:0] cfg_x [2], cfg_y [2], in_dest [2], out_dest [2];
  logic cfg_err [2], in_ready [2], out_valid [2], out_err [2];
  logic [2:0] out_port [2];
  logic [15:0] route_cnt [2], err_cnt [2];
  int cmp = 0, bad = 0;
  int gx [2] = '{16, 10};
  int gy [2] = '{16, 10};
  int nx [2] = '{7, 7};
  int ny [2] = '{8, 8};
  int nm [2] = '{0, 0};
  int head [2] = '{0, 0};
  int tail [2] = '{0, 0};
  int rc [2] = '{0, 0};
  int ec [2] = '{0, 0};
  int ecfg [2] = '{0, 0};
  int e_port [2][16], e_dest [2][16], e_err [2][16];
  always #5 clk = ~clk;
  rtable_router_stage u0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we[0]), .cfg_x(cfg_x[0]), .cfg_y(cfg_y[0]),
    .cfg_mode(cfg_mode[0]), .cfg_err(cfg_err[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_dest(in_dest[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_port(out_port[0]), .out_dest(out_dest[0]), .out_err(out_err[0]),
    .route_cnt(route_cnt[0]), .err_cnt(err_cnt[0])
  );
  rtable_router_stage #(.MESH_X(10), .MESH_Y(10)) u1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we[1]), .cfg_x(cfg_x[1]), .cfg_y(cfg_y[1]),
    .cfg_mode(cfg_mode[1]), .cfg_err(cfg_err[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_dest(in_dest[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_port(out_port[1]), .out_dest(out_dest[1]), .out_err(out_err[1]),
    .route_cnt(route_cnt[1]), .err_cnt(err_cnt[1])
  );
  task automatic chk(string nm_s, int i, int act, int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got %0h want %0h", nm_s, i, act, exp);
    end
  endtask
  // Signed offsets from the local node: the resolved dimension picks the sign-based direction.
  function automatic int exp_port(int i, int d);
    int ddx, ddy;
    if (d >= gx[i] * gy[i]) return 7;
    ddx = d % gx[i] - nx[i];
    ddy = d / gx[i] - ny[i];
    if (nm[i] == 1 && ddy != 0) return ddy > 0 ? 1 : 3;
    if (ddx != 0) return ddx > 0 ? 2 : 4;
    if (ddy != 0) return ddy > 0 ? 1 : 3;
    return 0;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        head[i] <= 0; tail[i] <= 0; rc[i] <= 0; ec[i] <= 0; ecfg[i] <= 0;
        nx[i] <= 7; ny[i] <= 8; nm[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && tail[i] - head[i] < 2) begin
          e_port[i][tail[i] % 16] <= exp_port(i, int'(in_dest[i]));
          e_dest[i][tail[i] % 16] <= int'(in_dest[i]);
          e_err[i][tail[i] % 16] <= int'(in_dest[i]) >= gx[i] * gy[i] ? 1 : 0;
          tail[i] <= tail[i] + 1;
          rc[i] <= rc[i] == 65535 ? rc[i] : rc[i] + 1;
          if (int'(in_dest[i]) >= gx[i] * gy[i]) ec[i] <= ec[i] == 65535 ? ec[i] : ec[i] + 1;
        end
        if (tail[i] != head[i] && out_ready[i]) head[i] <= head[i] + 1;
        ecfg[i] <= cfg_we[i] && (int'(cfg_x[i]) >= gx[i] || int'(cfg_y[i]) >= gy[i]) ? 1 : 0;
        if (cfg_we[i] && int'(cfg_x[i]) < gx[i] && int'(cfg_y[i]) < gy[i]) begin
          nx[i] <= int'(cfg_x[i]); ny[i] <= int'(cfg_y[i]); nm[i] <= int'(cfg_mode[i]);
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("in_ready", i, int'(in_ready[i]), tail[i] - head[i] < 2 ? 1 : 0);
      chk("out_valid", i, int'(out_valid[i]), tail[i] != head[i] ? 1 : 0);
      chk("cfg_err", i, int'(cfg_err[i]), ecfg[i]);
      chk("route_cnt", i, int'(route_cnt[i]), rc[i]);
      chk("err_cnt", i, int'(err_cnt[i]), ec[i]);
      if (tail[i] != head[i]) begin
        chk("out_port", i, int'(out_port[i]), e_port[i][head[i] % 16]);
        chk("out_dest", i, int'(out_dest[i]), e_dest[i][head[i] % 16]);
        chk("out_err", i, int'(out_err[i]), e_err[i][head[i] % 16]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(int i, int d, int ep);
    in_valid[i] = 1'b1;
    in_dest[i] = 8'(d);
    tick();
    in_valid[i] = 1'b0;
    @(negedge clk);
    chk("lit_valid", i, int'(out_valid[i]), 1);
    chk("lit_port", i, int'(out_port[i]), ep);
    tick();
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      cfg_we[i] = 0; cfg_x[i] = 0; cfg_y[i] = 0; cfg_mode[i] = 0;
      in_valid[i] = 0; in_dest[i] = 0; out_ready[i] = 1;
    end
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, int'(out_valid[i]), 0);
      chk("rst_ready", i, int'(in_ready[i]), 1);
      chk("rst_port", i, int'(out_port[i]), 0);
      chk("rst_cnt", i, int'(route_cnt[i]), 0);
    end
    rst_n = 1'b1;
    tick();
    xfer(0, 'h87, 0);
    xfer(0, 'h07, 3);
    xfer(0, 'h97, 1);
    xfer(0, 'h88, 2);
    xfer(0, 'h00, 4);
    chk("lit_route_cnt", 0, int'(route_cnt[0]), 5);
    cfg_we[0] = 1; cfg_x[0] = 7; cfg_y[0] = 8; cfg_mode[0] = 1;
    tick();
    cfg_we[0] = 0;
    xfer(0, 'h00, 3);
    xfer(0, 'h80, 4);
    cfg_we[0] = 1; cfg_x[0] = 0; cfg_y[0] = 0; cfg_mode[0] = 1;
    in_valid[0] = 1; in_dest[0] = 8'h87;
    tick();
    cfg_we[0] = 0; in_valid[0] = 0;
    @(negedge clk);
    chk("race_old_cfg", 0, int'(out_port[0]), 0);
    tick();
    xfer(0, 'h87, 1);
    out_ready[0] = 0;
    in_valid[0] = 1; in_dest[0] = 8'h11;
    tick();
    in_dest[0] = 8'h22;
    tick();
    in_dest[0] = 8'h33;
    @(negedge clk);
    chk("bp_ready", 0, int'(in_ready[0]), 0);
    chk("bp_head", 0, int'(out_dest[0]), 'h11);
    repeat (2) tick();
    @(negedge clk);
    chk("bp_stable", 0, int'(out_dest[0]), 'h11);
    tick();
    out_ready[0] = 1;
    @(negedge clk);
    chk("bp_nobypass", 0, int'(in_ready[0]), 0);
    tick();
    @(negedge clk);
    chk("bp_second", 0, int'(out_dest[0]), 'h22);
    tick();
    in_valid[0] = 0;
    @(negedge clk);
    chk("bp_third", 0, int'(out_dest[0]), 'h33);
    tick();
    @(negedge clk);
    chk("bp_drained", 0, int'(out_valid[0]), 0);
    tick();
    in_valid[1] = 1; in_dest[1] = 8'd100;
    tick();
    in_valid[1] = 0;
    @(negedge clk);
    chk("range_port", 1, int'(out_port[1]), 7);
    chk("range_err", 1, int'(out_err[1]), 1);
    chk("range_errcnt", 1, int'(err_cnt[1]), 1);
    tick();
    xfer(1, 99, 2);
    cfg_we[1] = 1; cfg_x[1] = 10; cfg_y[1] = 0; cfg_mode[1] = 1;
    tick();
    cfg_we[1] = 0;
    @(negedge clk);
    chk("cfg_err_pulse", 1, int'(cfg_err[1]), 1);
    tick();
    @(negedge clk);
    chk("cfg_err_drop", 1, int'(cfg_err[1]), 0);
    tick();
    xfer(1, 99, 2);
    out_ready[0] = 0; out_ready[1] = 0;
    in_valid[0] = 1; in_dest[0] = 8'h01;
    tick();
    in_dest[0] = 8'h02;
    tick();
    in_valid[0] = 0;
    @(negedge clk);
    chk("pre_rst_valid", 0, int'(out_valid[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 0, int'(out_valid[0]), 0);
    chk("midrst_cnt", 0, int'(route_cnt[0]), 0);
    chk("midrst_errcnt", 1, int'(err_cnt[1]), 0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready[0] = 1; out_ready[1] = 1;
    @(negedge clk);
    chk("post_rst_ready", 0, int'(in_ready[0]), 1);
    chk("post_rst_valid", 0, int'(out_valid[0]), 0);
    tick();
    xfer(0, 'h87, 0);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/rtable_router_stage.md
Name: rtable_router_stage

Overview:
Parametrised, registered successor to the fixed XY route lookup. Accepts destination IDs on a valid/ready stream and computes the output port for a runtime-programmable local node in a MESH_X x MESH_Y mesh. Supports XY or YX dimension order and flags out-of-range destinations. Results queue in a small output FIFO. Sits between the router input buffer and the switch allocator.

Parameters:
MESH_X, 16, mesh columns (>=2)
MESH_Y, 16, mesh rows (>=2)
ID_W, 8, destination ID width; must satisfy 2**ID_W >= MESH_X*MESH_Y
RESET_X, 7, local x coordinate after reset
RESET_Y, 8, local y coordinate after reset
DEPTH, 2, output FIFO entries (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_x  in  8  new local x
cfg_y  in  8  new local y
cfg_mode  in  1  0 = XY, 1 = YX routing
cfg_err  out  1  one-cycle pulse: rejected config write
in_valid  in  1  destination valid
in_ready  out  1  stage can accept
in_dest  in  ID_W  destination node ID = x + y*MESH_X
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_port  out  3  routed direction
out_dest  out  ID_W  echoed destination
out_err  out  1  head destination out of range
route_cnt  out  16  accepted destinations, saturating
err_cnt  out  16  out-of-range destinations, saturating

Behaviour:
- Reset (async assert, sync release): my_x=RESET_X, my_y=RESET_Y, mode=XY, FIFO empty, out_valid=0, out_port=0, out_dest=0, out_err=0, cfg_err=0, both counters 0, in_ready=1.
- Direction codes: LOCAL 3'b000, NORTH 3'b001, EAST 3'b010, SOUTH 3'b011, WEST 3'b100, INVALID 3'b111.
- Decode: dx = in_dest % MESH_X, dy = in_dest / MESH_X.
- XY mode:
  - dx==my_x and dy==my_y: LOCAL.
  - dx==my_x: SOUTH if dy<my_y, else NORTH.
  - otherwise: WEST if dx<my_x, else EAST.
- YX mode: y resolved first.
  - dy!=my_y: SOUTH/NORTH.
  - else dx!=my_x: WEST/EAST.
  - else LOCAL.
- in_dest >= MESH_X*MESH_Y: port INVALID, err flag 1. The entry is still queued and counted. err_cnt increments.
- Handshake:
  - Accept on in_valid & in_ready. Port is computed combinationally and written into the FIFO at that edge.
  - out_valid rises the following cycle (latency 1).
  - Pop on out_valid & out_ready.
- in_ready = (count < DEPTH). No full-bypass: with the FIFO full, a same-cycle pop does not enable a push.
- Push and pop in the same cycle when not full: count unchanged, pointers advance, and ordering is preserved.
- FIFO pointers wrap modulo DEPTH. out_* are stable while out_valid & !out_ready.
- Config:
  - cfg_we loads my_x, my_y and mode at the edge.
  - A destination accepted in the same cycle uses the old config.
  - Already-queued entries are never recomputed.
- cfg_x >= MESH_X or cfg_y >= MESH_Y: entire write ignored, mode included. cfg_err pulses high for exactly one cycle.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset mid-operation: all queued entries are discarded immediately and config returns to RESET_X/RESET_Y/XY.

Decomposition:
- Shared package rtable_pkg holds:
  - dir_t (3-bit enum) with the five codes plus DIR_INVALID.
  - route_mode_t (XY/YX).
  - function route_calc(dx, dy, my_x, my_y, mode).
- One sub-module: rtable_fifo, a parametrised DEPTH x (3+ID_W+1) synchronous FIFO with count, full and empty.
- Route logic and counters live in the top module.

Test Plan:
- Reset defaults, 16x16, node (7,8), XY:
  - in_dest 0x87 -> out_port 000
  - in_dest 0x07 -> 011 (SOUTH)
  - in_dest 0x97 -> 001 (NORTH)
  - in_dest 0x88 -> 010 (EAST)
  - in_dest 0x00 -> 100 (WEST)
  - Each has out_valid one cycle after acceptance; route_cnt=5.
- Mode switch: cfg_we with x=7, y=8, mode=1, then in_dest 0x00 -> 011 (SOUTH). in_dest 0x80 (x0,y8) -> 100 (WEST).
- Range check, MESH_X=MESH_Y=10:
  - in_dest 100 -> out_port 111, out_err=1, err_cnt=1.
  - in_dest 99 (9,9) from (7,8) -> EAST.
  - cfg_x=10 -> cfg_err pulse, config unchanged.
- Backpressure, DEPTH=2:
  - out_ready=0 with 3 back-to-back inputs -> in_ready low after 2 accepts, head stable.
  - Release out_ready -> outputs in order, no loss or duplication.
- Config race: cfg_we (x=0,y=0) in the same cycle as accepting 0x87 -> that entry is LOCAL. Next 0x87 -> NORTH.
- Reset mid-operation: FIFO holding 2 entries, assert rst_n low -> out_valid=0 and counters 0 immediately; after release, in_ready=1.
